irq_timer: RTL and testbench

IRQ_TIMER -- requirements
Module: irq_timer

---
 rtl/irq_timer_pkg.sv | 15 +
 rtl/irq_timer.sv | 84 ++++++++
 tb/tb_irq_timer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/irq_timer_pkg.sv
// irq_timer_pkg: register map, CTRL field positions, MODE codes and FSM state encodings shared by irq_timer
// Contents: ADDR_* word offsets, CTRL_* bit positions, MODE_RELOAD (any other MODE code runs one-shot), ST_* states.
package irq_timer_pkg;
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam int         CTRL_EN     = 0;
    localparam int         CTRL_MODE   = 1;
    localparam int         CTRL_IM     = 3;
    localparam logic [1:0] MODE_RELOAD = 2'd1;
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LOAD     = 2'd1;
    localparam logic [1:0] ST_CNT      = 2'd2;
    localparam logic [1:0] ST_INT      = 2'd3;
endpackage

// File: rtl/irq_timer.sv
// irq_timer: CPU-programmable countdown timer raising an interrupt when COUNT expires
// Ports: clk - system clock; reset - async active-low reset; addr - word offset (CTRL/PRESET/COUNT/unmapped);
//        we - write strobe; wdata - write data; rdata - combinational register read; irq - flag masked by IM.
module irq_timer
    import irq_timer_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    logic               en;
    logic               im;
    logic               irq_flag;
    logic [1:0]         mode;
    logic [1:0]         state;
    logic [COUNT_W-1:0] preset;
    logic [COUNT_W-1:0] count;
    logic               ctrl_wr;
    logic               preset_wr;
    logic [31:0]        ctrl_rd;
    assign ctrl_wr   = we && addr == ADDR_CTRL;
    assign preset_wr = we && addr == ADDR_PRESET;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en       <= 1'b0;
            im       <= 1'b0;
            mode     <= 2'd0;
            irq_flag <= 1'b0;
            preset   <= '0;
            count    <= '0;
            state    <= ST_IDLE;
        end else begin
            if (preset_wr) preset <= COUNT_W'(wdata);
            case (state)
                ST_IDLE: state <= en ? ST_LOAD : ST_IDLE;
                ST_LOAD: begin
                    if (en) count <= preset;
                    state <= en ? ST_CNT : ST_IDLE;
                end
                ST_CNT: begin
                    if (!en) state <= ST_IDLE;
                    else if (count > COUNT_W'(1)) count <= count - COUNT_W'(1);
                    else begin
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= ST_INT;
                    end
                end
                default: begin
                    if (mode == MODE_RELOAD) begin
                        irq_flag <= 1'b0;
                        state    <= ST_LOAD;
                    end else begin
                        en    <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
            endcase
            // Last assignment wins: a CPU write to CTRL overrides same-edge FSM updates of EN and irq_flag.
            if (ctrl_wr) begin
                en       <= wdata[CTRL_EN];
                mode     <= wdata[CTRL_MODE +: 2];
                im       <= wdata[CTRL_IM];
                irq_flag <= 1'b0;
            end
        end
    end
    always_comb begin
        ctrl_rd                 = '0;
        ctrl_rd[CTRL_EN]        = en;
        ctrl_rd[CTRL_MODE +: 2] = mode;
        ctrl_rd[CTRL_IM]        = im;
        rdata = addr == ADDR_CTRL   ? ctrl_rd :
                addr == ADDR_PRESET ? 32'(preset) :
                addr == ADDR_COUNT  ? 32'(count) : '0;
    end
    assign irq = irq_flag & im;
endmodule

// File: tb/tb_irq_timer.sv
// tb_irq_timer: directed and randomized checks of irq_timer against a cycle-timed behavioural model
module tb_irq_timer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    irq_timer #(.COUNT_W(32)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: run position m_t (-1 stopped, 0 load due on next edge, k>=1 next countdown edge is the k-th),
    // countdown value derived from elapsed edges, m_fire marks the one interrupt-service edge.
    bit          m_en, m_im, m_flag, m_fire;
    bit [1:0]    m_mode;
    logic [31:0] m_preset, m_count, m_p;
    int          m_t;

    function automatic void m_reset();
        m_en = 0; m_im = 0; m_flag = 0; m_fire = 0; m_mode = 0;
        m_preset = 0; m_count = 0; m_p = 0; m_t = -1;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step(input bit w, input logic [1:0] a, input logic [31:0] d);
        bit n_en   = m_en;
        bit n_flag = m_flag;
        int goal   = (m_p == 0) ? 1 : int'(m_p);
        if (m_fire) begin
            m_fire = 0;
            if (m_mode == 2'd1) begin n_flag = 0; m_t = 0; end
            else begin n_en = 0; m_t = -1; end
        end else if (!m_en) m_t = -1;
        else if (m_t < 0) m_t = 0;
        else if (m_t == 0) begin
            m_p = m_preset; m_count = m_preset; m_t = 1;
        end else if (m_t >= goal) begin
            m_count = 0; n_flag = 1; m_fire = 1;
        end else begin
            m_count = m_p - 32'(m_t); m_t++;
        end
        if (w && a == 2'd0) begin
            n_en = d[0]; m_mode = d[2:1]; m_im = d[3]; n_flag = 0;
        end
        if (w && a == 2'd1) m_preset = d;
        m_en = n_en;
        m_flag = n_flag;
    endtask

    task automatic cyc(input bit w = 0, input logic [1:0] a = 2'd0, input logic [31:0] d = 0);
        we = w; addr = a; wdata = d;
        @(negedge clk);
        check("rdata", rdata, m_read(a));
        check("irq", 32'(irq), 32'(m_flag & m_im));
        @(posedge clk);
        m_step(w, a, d);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(1, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 2'($urandom_range(3)), 0);
    endtask

    task automatic wait_irq(input int limit, output int n);
        n = 0;
        while (irq !== 1'b1 && n < limit) begin cyc(0, 2'd2, 0); n++; end
    endtask

    task automatic read_now(input logic [1:0] a, output logic [31:0] v);
        we = 0; addr = a; #1; v = rdata;
    endtask

    int          n;
    int          saw;
    logic [31:0] v;

    initial begin
        m_reset();
        #1 reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a); #1;
            check("reset_rdata", rdata, 32'd0);
        end
        check("reset_irq", 32'(irq), 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); m_step(0, 0, 0); #1;

        // one-shot, PRESET=3: irq after 5 cycles and held
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        wait_irq(20, n);
        check("oneshot_latency", n, 5);
        cyc(0, 2'd0, 0);
        cyc(0, 2'd0, 0);
        check("oneshot_held", 32'(irq), 32'd1);
        read_now(2'd0, v); check("oneshot_ctrl_en_cleared", v, 32'h8);
        read_now(2'd2, v); check("oneshot_count_zero", v, 32'd0);

        // CTRL=0x8 clears the interrupt, timer stays idle
        wr(2'd0, 32'h8);
        check("ctrl_write_clears_irq", 32'(irq), 32'd0);
        idle(10);
        check("stays_idle_irq", 32'(irq), 32'd0);
        read_now(2'd2, v); check("stays_idle_count", v, 32'd0);

        // auto-reload, PRESET=2: single-cycle pulse every 4 cycles
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        wait_irq(20, n);
        check("reload_latency", n, 4);
        for (int p = 0; p < 3; p++) begin
            cyc(0, 2'd2, 0);
            check("reload_pulse_width", 32'(irq), 32'd0);
            n = 1;
            while (irq !== 1'b1 && n < 20) begin cyc(0, 2'd2, 0); n++; end
            check("reload_period", n, 4);
        end

        // IM=0 countdown hides irq; re-enable clears flag and restarts
        wr(2'd0, 32'h0);
        idle(4);
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        idle(14);
        check("masked_irq", 32'(irq), 32'd0);
        read_now(2'd2, v); check("masked_count_zero", v, 32'd0);
        wr(2'd0, 32'h9);
        check("reenable_flag_cleared", 32'(irq), 32'd0);
        wait_irq(30, n);
        check("reenable_latency", n, 12);

        // PRESET rewritten mid-count in auto-reload
        wr(2'd0, 32'h0);
        idle(4);
        wr(2'd1, 32'd5);
        wr(2'd0, 32'hB);
        n = 0;
        repeat (3) begin cyc(0, 2'd2, 0); n++; end
        wr(2'd1, 32'd2);
        n++;
        while (irq !== 1'b1 && n < 30) begin cyc(0, 2'd2, 0); n++; end
        check("preset_midcount_period", n, 7);
        wait_irq(1, n);
        cyc(0, 2'd2, 0);
        n = 1;
        while (irq !== 1'b1 && n < 30) begin cyc(0, 2'd2, 0); n++; end
        check("preset_next_period", n, 4);

        // reset mid-count aborts the countdown
        wr(2'd0, 32'h0);
        idle(4);
        wr(2'd1, 32'd100);
        wr(2'd0, 32'h9);
        n = 0;
        while (rdata !== 32'd50 && n < 200) begin cyc(0, 2'd2, 0); n++; end
        check("count_reaches_50", n, 52);
        #2 reset = 1'b0;
        m_reset();
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a); #1;
            check("midcount_reset_rdata", rdata, 32'd0);
        end
        check("midcount_reset_irq", 32'(irq), 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); m_step(0, 0, 0); #1;
        saw = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(0, 2'($urandom_range(3)), 0);
            if (irq === 1'b1) saw++;
        end
        check("no_irq_after_reset", saw, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 12) begin
                logic [1:0]  a = 2'($urandom_range(3));
                logic [31:0] d = $urandom;
                if (a == 2'd1) d = ($urandom_range(15) == 0) ? 32'($urandom_range(1000, 100000)) : 32'($urandom_range(12));
                if (a == 2'd0 && $urandom_range(3) != 0) d[0] = 1'b1;
                wr(a, d);
            end else cyc(0, 2'($urandom_range(3)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
